// File: rtl/trap_sequencer.sv
// trap_sequencer: commit-boundary trap entry / mret sequencer, single writer of mepc, mcause, mstatus and privilege.
// Ports: commit_* / exc_* / mret_valid sample the committing instruction; priv_mode and mstatus/mip/mie/mtvec/mepc
// give current CSR state; stall holds upstream, csr_we/csr_addr/csr_wdata write one CSR per cycle,
// priv_we/priv_next update privilege, redirect_valid/redirect_pc flush and refetch, busy flags a sequence in progress.
module trap_sequencer #(
  parameter int XLEN = 64,
  parameter logic [11:0] MEPC_ADDR = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR = 12'h342,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [XLEN-1:0] commit_next_pc,
  input  logic            exc_valid,
  input  logic [3:0]      exc_code,
  input  logic            mret_valid,
  input  logic [1:0]      priv_mode,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mip,
  input  logic [XLEN-1:0] mie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            stall,
  output logic            csr_we,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            priv_we,
  output logic [1:0]      priv_next,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, M_STATUS, REDIRECT} state_t;
  state_t state, state_n;
  logic [XLEN-1:0] epc_q, cause_q, ms_q, tvec_q, mepc_q, trap_ms, ret_ms, trap_pc;
  logic [1:0] priv_q;
  logic is_int_q, ret_q;
  logic [2:0] pend;
  logic int_en, int_hit, take_exc, take_int, take_ret, accept;
  logic [3:0] int_code;
  logic unused;
  assign unused = ^{mip, mie};
  assign pend = {mip[11] & mie[11], mip[3] & mie[3], mip[7] & mie[7]};
  assign int_en = (priv_mode == 2'd3 && mstatus[3]) || priv_mode == 2'd0;
  assign int_code = pend[2] ? 4'd11 : pend[1] ? 4'd3 : 4'd7;
  assign int_hit = int_en && |pend;
  assign take_exc = commit_valid && exc_valid;
  assign take_int = commit_valid && !exc_valid && int_hit;
  assign take_ret = commit_valid && !exc_valid && !int_hit && mret_valid;
  // rst gating keeps stall low while reset is held even if commit inputs toggle
  assign accept = state == IDLE && !rst && (take_exc || take_int || take_ret);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      epc_q <= '0;
      cause_q <= '0;
      ms_q <= '0;
      tvec_q <= '0;
      mepc_q <= '0;
      priv_q <= '0;
      is_int_q <= 1'b0;
      ret_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        epc_q <= take_exc ? commit_pc : commit_next_pc;
        cause_q <= take_exc ? {{(XLEN-4){1'b0}}, exc_code} : {1'b1, {(XLEN-5){1'b0}}, int_code};
        is_int_q <= take_int;
        ret_q <= take_ret;
        ms_q <= mstatus;
        priv_q <= priv_mode;
        tvec_q <= mtvec;
        mepc_q <= mepc;
      end
    end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = !accept ? IDLE : take_ret ? M_STATUS : W_EPC;
      W_EPC:    state_n = W_CAUSE;
      W_CAUSE:  state_n = W_STATUS;
      W_STATUS: state_n = REDIRECT;
      M_STATUS: state_n = REDIRECT;
      default:  state_n = IDLE;
    endcase
  end
  always_comb begin
    trap_ms = ms_q;
    trap_ms[7] = ms_q[3];
    trap_ms[3] = 1'b0;
    trap_ms[12:11] = priv_q;
    ret_ms = ms_q;
    ret_ms[3] = ms_q[7];
    ret_ms[7] = 1'b1;
    ret_ms[12:11] = 2'd0;
  end
  // vectored mode offsets only interrupts; modes 2 and 3 fall back to direct
  assign trap_pc = {tvec_q[XLEN-1:2], 2'b00} +
                   ((tvec_q[1:0] == 2'd1 && is_int_q) ? XLEN'({cause_q[3:0], 2'b00}) : '0);
  assign busy = state != IDLE;
  assign stall = busy || accept;
  assign csr_we = state == W_EPC || state == W_CAUSE || state == W_STATUS || state == M_STATUS;
  assign csr_addr = state == W_EPC ? MEPC_ADDR : state == W_CAUSE ? MCAUSE_ADDR : csr_we ? MSTATUS_ADDR : '0;
  assign csr_wdata = state == W_EPC ? epc_q : state == W_CAUSE ? cause_q :
                     state == W_STATUS ? trap_ms : state == M_STATUS ? ret_ms : '0;
  assign priv_we = state == W_STATUS || state == M_STATUS;
  assign priv_next = state == W_STATUS ? 2'd3 : state == M_STATUS ? ms_q[12:11] : 2'd0;
  assign redirect_valid = state == REDIRECT;
  assign redirect_pc = state != REDIRECT ? '0 : ret_q ? mepc_q : trap_pc;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scoreboard bench for trap_sequencer with directed cases and randomized commits.
module tb_trap_sequencer;
  logic clk = 0, rst = 1;
  logic commit_valid = 0, exc_valid = 0, mret_valid = 0;
  logic [63:0] commit_pc = 0, commit_next_pc = 0, mstatus = 0, mip = 0, mie = 0, mtvec = 0, mepc = 0;
  logic [3:0] exc_code = 0;
  logic [1:0] priv_mode = 0;
  logic stall, csr_we, priv_we, redirect_valid, busy;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, redirect_pc;
  logic [1:0] priv_next;
  typedef struct {
    int cyc;
    logic we;
    logic [11:0] addr;
    logic [63:0] wd;
    logic pwe;
    logic [1:0] pn;
    logic rv;
    logic [63:0] rpc;
  } exp_t;
  exp_t q[$];
  int cyc = 0, checks = 0, errors = 0, bstart = -10, bend = -10;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  trap_sequencer dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_next_pc(commit_next_pc), .exc_valid(exc_valid), .exc_code(exc_code),
    .mret_valid(mret_valid), .priv_mode(priv_mode), .mstatus(mstatus), .mip(mip), .mie(mie),
    .mtvec(mtvec), .mepc(mepc), .stall(stall), .csr_we(csr_we), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .priv_we(priv_we), .priv_next(priv_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .busy(busy)
  );
  function automatic exp_t mk(int c, logic we, logic [11:0] a, logic [63:0] d, logic pwe,
                              logic [1:0] pn, logic rv, logic [63:0] rpc);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wd = d; e.pwe = pwe; e.pn = pn; e.rv = rv; e.rpc = rpc;
    return e;
  endfunction
  // reference: picks the outcome from the architectural rules and queues the whole write sequence
  task automatic model(input logic ev, input logic [3:0] ec, input logic mv, input logic [1:0] pm,
                       input logic [63:0] pc, npc, ms, ip, ie, tv, ep);
    int pri[3] = '{11, 3, 7};
    int code = -1;
    int c = cyc;
    logic [63:0] pend = ip & ie, cause, epc, tgt;
    bit en = (pm == 3 && ms[3]) || pm == 0;
    bit is_int = 0;
    foreach (pri[i]) if (code < 0 && pend[pri[i]]) code = pri[i];
    if (ev || (en && code >= 0)) begin
      is_int = !ev;
      epc = ev ? pc : npc;
      cause = ev ? 64'(ec) : ((64'd1 << 63) | 64'(code));
      tgt = (tv & ~64'h3) + ((tv % 4 == 1 && is_int) ? 64'(4 * code) : 64'd0);
      q.push_back(mk(c + 1, 1, 12'h341, epc, 0, 0, 0, 0));
      q.push_back(mk(c + 2, 1, 12'h342, cause, 0, 0, 0, 0));
      q.push_back(mk(c + 3, 1, 12'h300, (ms & ~64'h1888) | (64'(ms[3]) << 7) | (64'(pm) << 11), 1, 3, 0, 0));
      q.push_back(mk(c + 4, 0, 0, 0, 0, 0, 1, tgt));
      bstart = c;
      bend = c + 4;
    end else if (mv) begin
      q.push_back(mk(c + 1, 1, 12'h300, (ms & ~64'h1888) | (64'(ms[7]) << 3) | 64'h80, 1, ms[12:11], 0, 0));
      q.push_back(mk(c + 2, 0, 0, 0, 0, 0, 1, ep));
      bstart = c;
      bend = c + 2;
    end
  endtask
  task automatic drive(input logic cv, ev, input logic [3:0] ec, input logic mv, input logic [1:0] pm,
                       input logic [63:0] pc, npc, ms, ip, ie, tv, ep);
    commit_valid = cv; exc_valid = ev; exc_code = ec; mret_valid = mv; priv_mode = pm;
    commit_pc = pc; commit_next_pc = npc; mstatus = ms; mip = ip; mie = ie; mtvec = tv; mepc = ep;
    if (cv && cyc > bend) model(ev, ec, mv, pm, pc, npc, ms, ip, ie, tv, ep);
    @(posedge clk);
    #1;
    commit_valid = 0; exc_valid = 0; mret_valid = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk_zero(input string name);
    checks++;
    if ({stall, busy, csr_we, priv_we, redirect_valid} !== 5'd0 || csr_addr !== 12'd0 ||
        csr_wdata !== 64'd0 || priv_next !== 2'd0 || redirect_pc !== 64'd0) begin
      errors++;
      $display("FAIL %s: outputs stall=%b busy=%b we=%b addr=%h wd=%h pwe=%b pn=%0d rv=%b rpc=%h, required all 0",
               name, stall, busy, csr_we, csr_addr, csr_wdata, priv_we, priv_next, redirect_valid, redirect_pc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic st_exp, bz_exp;
    st_exp = cyc >= bstart && cyc <= bend;
    bz_exp = cyc > bstart && cyc <= bend;
    checks++;
    if (stall !== st_exp || busy !== bz_exp) begin
      errors++;
      $display("FAIL stall/busy cyc %0d: got %b/%b, required %b/%b", cyc, stall, busy, st_exp, bz_exp);
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing event due cyc %0d: got nothing, required we=%b addr=%h wd=%h rv=%b rpc=%h",
               e.cyc, e.we, e.addr, e.wd, e.rv, e.rpc);
    end
    if (csr_we || priv_we || redirect_valid) begin
      checks++;
      if (q.size() == 0 || q[0].cyc != cyc) begin
        errors++;
        $display("FAIL unexpected event cyc %0d: got we=%b addr=%h wd=%h pwe=%b rv=%b rpc=%h, required none",
                 cyc, csr_we, csr_addr, csr_wdata, priv_we, redirect_valid, redirect_pc);
      end else begin
        e = q.pop_front();
        if (e.we !== csr_we || e.pwe !== priv_we || e.rv !== redirect_valid ||
            (e.we && (csr_addr !== e.addr || csr_wdata !== e.wd)) || (e.pwe && priv_next !== e.pn) ||
            (e.rv && redirect_pc !== e.rpc)) begin
          errors++;
          $display("FAIL event cyc %0d: got we=%b addr=%h wd=%h pwe=%b pn=%0d rv=%b rpc=%h, required we=%b addr=%h wd=%h pwe=%b pn=%0d rv=%b rpc=%h",
                   cyc, csr_we, csr_addr, csr_wdata, priv_we, priv_next, redirect_valid, redirect_pc,
                   e.we, e.addr, e.wd, e.pwe, e.pn, e.rv, e.rpc);
        end
      end
    end
  end
  initial begin
    int c;
    idle(2);
    chk_zero("reset");
    rst = 0;
    idle(2);
    drive(1, 1, 2, 0, 0, 64'h8000_0010, 64'h8000_0014, 0, 0, 0, 64'h8000_0100, 0);
    idle(6);
    drive(1, 0, 0, 0, 3, 64'h8000_0020, 64'h8000_0024, 64'h8, 64'h80, 64'h80, 64'h8000_0001, 0);
    idle(6);
    drive(1, 0, 0, 0, 0, 64'h8000_0030, 64'h8000_0034, 0, 64'h888, 64'h888, 64'h8000_0001, 0);
    idle(6);
    drive(1, 0, 0, 0, 3, 64'h8000_0040, 64'h8000_0044, 0, 64'h888, 64'h888, 64'h8000_0001, 0);
    idle(2);
    drive(1, 1, 5, 0, 3, 64'h8000_0050, 64'h8000_0054, 64'h8, 64'h800, 64'h800, 64'h8000_0001, 0);
    idle(6);
    drive(1, 0, 0, 1, 3, 64'h8000_0060, 64'h8000_0064, 64'h1880, 0, 0, 64'h8000_0100, 64'h8000_0200);
    idle(4);
    repeat (6) drive(1, 1, 4, 0, 0, 64'h8000_0070, 64'h8000_0074, 64'h1808, 0, 0, 64'h8000_0300, 0);
    idle(6);
    c = cyc;
    drive(1, 1, 7, 0, 3, 64'h8000_0080, 64'h8000_0084, 64'h8, 0, 0, 64'h8000_0400, 0);
    idle(2);
    rst = 1;
    #1;
    chk_zero("rst_mid");
    q.delete();
    bend = c + 2;
    idle(1);
    rst = 0;
    idle(3);
    repeat (400) begin
      logic [63:0] ip, ie;
      ip = 64'(($urandom & 32'hfff) | ($urandom_range(0, 1) ? 32'h888 : 32'h0)) & {32'b0, $urandom};
      ie = 64'($urandom) | ({32'b0, $urandom} << 32);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 3) == 0,
            2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            ip, ie, {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(8);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d events outstanding, required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle controller that owns trap entry and `mret` return at the commit boundary.
- Samples each committing instruction, decides whether an exception or interrupt is taken, and arbitrates the pending interrupts by fixed priority.
- Sequences the CSR writes (`mepc`, `mcause`, `mstatus`) and the privilege change one per cycle, then issues a single pipeline flush and redirect.
- Sits between the writeback stage and the CSR file; it is the single writer of trap-related CSR state.

Parameters:
- XLEN, 64, data/CSR width.
- MEPC_ADDR, 12'h341, CSR address of `mepc`.
- MCAUSE_ADDR, 12'h342, CSR address of `mcause`.
- MSTATUS_ADDR, 12'h300, CSR address of `mstatus`.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- commit_valid  in  1  an instruction reaches the commit boundary this cycle
- commit_pc  in  XLEN  pc of the committing instruction
- commit_next_pc  in  XLEN  architectural next pc of the committing instruction
- exc_valid  in  1  committing instruction raised a synchronous exception
- exc_code  in  4  exception cause code
- mret_valid  in  1  committing instruction is `mret`
- priv_mode  in  2  current privilege (0=U, 3=M)
- mstatus, mip, mie, mtvec, mepc  in  XLEN  current CSR values
- stall  out  1  hold the pipeline upstream of commit
- csr_we  out  1  CSR write strobe
- csr_addr  out  12  CSR write address
- csr_wdata  out  XLEN  CSR write data
- priv_we  out  1  load priv_next into the privilege register
- priv_next  out  2  new privilege
- redirect_valid  out  1  flush the pipeline and fetch from redirect_pc
- redirect_pc  out  XLEN  redirect target
- busy  out  1  FSM is not in IDLE

Behaviour:
- Reset is asynchronous and active-high on rst; clock is clk.
- Reset state: FSM=IDLE, all outputs 0, latched registers 0.
- Reset mid-sequence aborts to IDLE. Any partial CSR writes already issued stay as they are; no redirect is issued.
- FSM states: IDLE, W_EPC, W_CAUSE, W_STATUS, M_STATUS, REDIRECT.
- Interrupts are globally enabled when (priv_mode==3 and mstatus[3]) or priv_mode==0.
- pend = mip & mie. Interrupt priority: bit 11 (MEI) > bit 3 (MSI) > bit 7 (MTI). Other bits are ignored.
- Decision in IDLE, evaluated only when commit_valid=1 (call this the accept cycle T):
  - exc_valid: take exception. Latch epc=commit_pc, cause={0,exc_code zero-extended}, is_int=0. Next state W_EPC.
  - else if enabled and pend selects a bit: take interrupt after the instruction retires. Latch epc=commit_next_pc, cause={1 at bit XLEN-1, code}, is_int=1. Next state W_EPC.
  - else if mret_valid: next state M_STATUS.
  - else: stay in IDLE; no outputs.
  - Exception beats interrupt beats mret.
- At T, also latch mstatus, priv_mode, mtvec and mepc.
- stall = (IDLE and a trap or mret is taken at T) or busy. It is combinational at T and registered afterwards.
- While busy, all commit_* inputs are ignored.
- W_EPC: csr_we=1, csr_addr=MEPC_ADDR, csr_wdata=epc. Next state W_CAUSE.
- W_CAUSE: csr_we=1, csr_addr=MCAUSE_ADDR, csr_wdata=cause. Next state W_STATUS.
- W_STATUS: write MSTATUS_ADDR with the latched mstatus modified as follows; all other bits unchanged:
  - MPIE(7) = MIE(3)
  - MIE(3) = 0
  - MPP(12:11) = latched priv
  - Same cycle: priv_we=1, priv_next=3. Next state REDIRECT.
- Trap target: redirect_pc = {mtvec[XLEN-1:2], 2'b00}.
  - If mtvec[1:0]==1 and is_int, add 4*code to that base.
  - mtvec[1:0] of 2 or 3 is treated as direct mode.
- M_STATUS (mret): write mstatus with the following changes:
  - MIE = MPIE
  - MPIE = 1
  - MPP = 0
  - Same cycle: priv_we=1, priv_next=latched MPP. Next state REDIRECT with redirect_pc = latched mepc.
- REDIRECT: redirect_valid=1 for exactly one cycle. Next state IDLE; stall drops in the following cycle.
- Latency:
  - Trap: T+1 mepc, T+2 mcause, T+3 mstatus/priv, T+4 redirect, T+5 idle (stall high T..T+4).
  - mret: T+1 status/priv, T+2 redirect.
- Exactly one csr_we pulse per state; csr_we is never asserted together with redirect_valid.

Test Plan:
- Exception: commit_valid=1, exc_valid=1, exc_code=2, commit_pc=0x8000_0010, priv=0, mtvec=0x8000_0100.
  -> mepc=0x8000_0010 at T+1, mcause=2 at T+2, mstatus MPP=0 / MIE=0 at T+3 with priv_next=3, redirect to 0x8000_0100 at T+4.
- Timer interrupt, vectored: priv=3, mstatus=0x8, mip=mie=0x80, mtvec=0x8000_0001, commit_next_pc=0x8000_0024.
  -> mepc=0x8000_0024, mcause=0x8000_0000_0000_0007, MPIE=1, MIE=0, MPP=3, redirect to 0x8000_001C.
- Priority and masking:
  - mip=mie=0x888 -> mcause code 11.
  - Same with priv=3 and mstatus[3]=0 -> no trap, stall=0.
  - exc_valid=1 together with pending MEI -> exception cause taken.
- mret: mstatus=0x1880 (MPP=3, MPIE=1), mepc=0x8000_0200, mret_valid=1.
  -> mstatus written 0x88 at T+1 with priv_next=3, redirect to 0x8000_0200 at T+2, stall high for exactly 3 cycles.
- Busy ignore and reset: commit_valid/exc_valid pulses during W_CAUSE cause no second sequence. rst asserted in W_STATUS -> all outputs 0 immediately, IDLE, no redirect.
- Back-to-back: a second exception commit in the cycle after REDIRECT is accepted and produces a full, identical 5-cycle sequence.
